// File: rtl/approx_eval_pkg.sv
// Shared definitions for the approximate-circuit error sweeper.
//   sweep_state_e : sweep FSM states
//   DrainLen      : cycles spent flushing the compare pipeline after the last vector
//   widths_ok()   : parameter legality check (even input count, N_OUT == N_IN/2 + 1)
package approx_eval_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSweep,
        StDrain,
        StDone
    } sweep_state_e;

    localparam int unsigned DrainLen = 2;

    function automatic bit widths_ok(input int unsigned n_in, input int unsigned n_out);
        return ((n_in % 2) == 0) && (n_out == (n_in / 2 + 1));
    endfunction

endpackage

// File: rtl/exact_adder_ref.sv
// Golden reference for the sweeper: exact unsigned A + B, purely combinational.
//   in_vec : stimulus vector; A = in_vec[N_IN/2-1:0], B = in_vec[N_IN-1:N_IN/2]
//   sum    : exact A + B, N_OUT bits wide (cannot overflow when N_OUT = N_IN/2 + 1)
module exact_adder_ref #(
    parameter int unsigned N_IN  = 4,
    parameter int unsigned N_OUT = 3
) (
    input  logic [N_IN-1:0]  in_vec,
    output logic [N_OUT-1:0] sum
);

    localparam int unsigned Half = N_IN / 2;

    logic [Half-1:0] op_a;
    logic [Half-1:0] op_b;

    assign op_a = in_vec[Half-1:0];
    assign op_b = in_vec[N_IN-1:Half];
    assign sum  = N_OUT'(op_a) + N_OUT'(op_b);

endmodule

// File: rtl/approx_error_sweeper.sv
// Exhaustive error sweeper for an external approximate adder netlist.
// Drives every input vector, compares the response against exact_adder_ref and
// accumulates worst-case absolute error and the number of erroneous vectors.
//   clk, rst  : clock (rising edge), asynchronous active-high reset
//   start     : launch a sweep (honoured only in IDLE or DONE)
//   dut_in    : registered stimulus to the approximate circuit
//   dut_out   : combinational response of the approximate circuit
//   busy      : sweep or drain in progress
//   done      : results final; held until the next accepted start
//   max_err   : largest |exact - approx| so far
//   err_count : number of vectors with nonzero error
//   pass      : max_err <= ET, qualified by done
module approx_error_sweeper
    import approx_eval_pkg::*;
#(
    parameter int unsigned N_IN  = 4,
    parameter int unsigned N_OUT = 3,
    parameter int unsigned ET    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [N_IN-1:0]   dut_in,
    input  logic [N_OUT-1:0]  dut_out,
    output logic              busy,
    output logic              done,
    output logic [N_OUT-1:0]  max_err,
    output logic [N_IN:0]     err_count,
    output logic              pass
);

    if (!widths_ok(N_IN, N_OUT)) begin : g_bad_width
        $error("approx_error_sweeper: N_IN must be even and N_OUT must equal N_IN/2+1");
    end

    localparam int unsigned   DrainW  = (DrainLen > 1) ? $clog2(DrainLen) : 1;
    localparam logic [N_IN-1:0] LastVec = {N_IN{1'b1}};

    sweep_state_e      state_q, state_d;
    logic [N_IN-1:0]   vec_q, vec_d;
    logic [DrainW-1:0] drain_q, drain_d;
    logic              clear;

    logic [N_OUT-1:0]  exact;
    logic              s1_valid_q;
    logic [N_OUT-1:0]  s1_exact_q;
    logic [N_OUT-1:0]  s1_approx_q;
    logic [N_OUT-1:0]  diff;
    logic [N_OUT-1:0]  max_err_q;
    logic [N_IN:0]     err_count_q;

    exact_adder_ref #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT)
    ) u_ref (
        .in_vec (vec_q),
        .sum    (exact)
    );

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        drain_d = drain_q;
        clear   = 1'b0;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StSweep;
                    vec_d   = '0;
                    clear   = 1'b1;
                end
            end
            StSweep: begin
                // Counter holds on the last vector so dut_in keeps it through DRAIN/DONE.
                if (vec_q == LastVec) begin
                    state_d = StDrain;
                    drain_d = '0;
                end else begin
                    vec_d = vec_q + 1'b1;
                end
            end
            StDrain: begin
                if (drain_q == DrainW'(DrainLen - 1)) begin
                    state_d = StDone;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            vec_q   <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            drain_q <= drain_d;
        end
    end

    // Unsigned compare-then-subtract keeps the magnitude within N_OUT bits.
    assign diff = (s1_exact_q >= s1_approx_q) ? (s1_exact_q - s1_approx_q)
                                              : (s1_approx_q - s1_exact_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_exact_q  <= '0;
            s1_approx_q <= '0;
            max_err_q   <= '0;
            err_count_q <= '0;
        end else begin
            s1_exact_q  <= exact;
            s1_approx_q <= dut_out;
            if (clear) begin
                s1_valid_q  <= 1'b0;
                max_err_q   <= '0;
                err_count_q <= '0;
            end else begin
                s1_valid_q <= (state_q == StSweep);
                if (s1_valid_q) begin
                    if (diff > max_err_q) begin
                        max_err_q <= diff;
                    end
                    err_count_q <= err_count_q + (N_IN + 1)'(diff != '0);
                end
            end
        end
    end

    assign dut_in    = vec_q;
    assign busy      = (state_q == StSweep) || (state_q == StDrain);
    assign done      = (state_q == StDone);
    assign max_err   = max_err_q;
    assign err_count = err_count_q;
    assign pass      = done && (32'(max_err_q) <= ET);

endmodule

// File: tb/tb_approx_error_sweeper.sv
module tb_approx_error_sweeper;

    typedef struct packed {
        logic [2:0] max;
        logic [4:0] cnt;
        logic       pas;
    } res_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] mode;
    logic [3:0] dut_in, dut_in6;
    logic [2:0] dut_out, max_err, max_err6;
    logic [4:0] err_count, err_count6;
    logic       busy, done, pass, busy6, done6, pass6;

    res_t sb_q[$];
    res_t sb6_q[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    // Approximate circuit under evaluation: 0 exact, 1 constant 3, 2 stuck-at-zero.
    always_comb begin
        dut_out = 3'd0;
        case (mode)
            2'd0:    dut_out = {1'b0, dut_in[1:0]} + {1'b0, dut_in[3:2]};
            2'd1:    dut_out = 3'd3;
            default: dut_out = 3'd0;
        endcase
    end

    approx_error_sweeper #(.N_IN(4), .N_OUT(3), .ET(3)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dut_in    (dut_in),
        .dut_out   (dut_out),
        .busy      (busy),
        .done      (done),
        .max_err   (max_err),
        .err_count (err_count),
        .pass      (pass)
    );

    // Second sweeper with a looser bound, always seeing a stuck-at-zero circuit.
    approx_error_sweeper #(.N_IN(4), .N_OUT(3), .ET(6)) u_dut6 (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dut_in    (dut_in6),
        .dut_out   (3'b000),
        .busy      (busy6),
        .done      (done6),
        .max_err   (max_err6),
        .err_count (err_count6),
        .pass      (pass6)
    );

    function automatic res_t model(input logic [1:0] m, input int et);
        res_t r;
        int   ex, ap, d;
        r = '0;
        for (int v = 0; v < 16; v++) begin
            ex = (v % 4) + (v / 4);
            ap = (m == 2'd0) ? ex : (m == 2'd1) ? 3 : 0;
            d  = (ex >= ap) ? ex - ap : ap - ex;
            if (d > int'(r.max)) r.max = 3'(d);
            if (d != 0) r.cnt = r.cnt + 5'd1;
        end
        r.pas = (int'(r.max) <= et);
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_results(input string tag);
        res_t e, e6;
        e  = sb_q.pop_front();
        e6 = sb6_q.pop_front();
        chk({tag, " max_err"}, int'(max_err), int'(e.max));
        chk({tag, " err_count"}, int'(err_count), int'(e.cnt));
        chk({tag, " pass"}, int'(pass), int'(e.pas));
        chk({tag, " et6 max_err"}, int'(max_err6), int'(e6.max));
        chk({tag, " et6 err_count"}, int'(err_count6), int'(e6.cnt));
        chk({tag, " et6 pass"}, int'(pass6), int'(e6.pas));
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        mode  = 2'd0;
        @(negedge clk);
        chk("reset dut_in", int'(dut_in), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset max_err", int'(max_err), 0);
        chk("reset err_count", int'(err_count), 0);
        chk("reset pass", int'(pass), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle done", int'(done), 0);
    endtask

    // One full sweep; optionally re-pulses start mid-sweep, which must be ignored.
    task automatic run_sweep(input string tag, input logic [1:0] m, input bit extra_starts);
        int cyc;
        mode = m;
        sb_q.push_back(model(m, 3));
        sb6_q.push_back(model(2'd2, 6));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        chk({tag, " busy at t0"}, int'(busy), 1);
        chk({tag, " pass gated"}, int'(pass), 0);
        while (!done && cyc < 40) begin
            if (cyc < 16 && dut_in !== 4'(cyc)) begin
                chk({tag, " dut_in seq"}, int'(dut_in), cyc);
            end
            start = extra_starts && (cyc == 5 || cyc == 17);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk({tag, " done cycle"}, cyc, 18);
        if (!done) begin
            void'(sb_q.pop_front());
            void'(sb6_q.pop_front());
        end else begin
            chk({tag, " busy at done"}, int'(busy), 0);
            chk({tag, " dut_in held"}, int'(dut_in), 15);
            check_results(tag);
            @(negedge clk);
            chk({tag, " done held"}, int'(done), 1);
        end
    endtask

    task automatic test_exact();
        run_sweep("exact", 2'd0, 1'b0);
    endtask

    task automatic test_const3();
        run_sweep("const3", 2'd1, 1'b0);
    endtask

    task automatic test_stuck0();
        run_sweep("stuck0", 2'd2, 1'b0);
    endtask

    task automatic test_ignored_start();
        run_sweep("ignored_start", 2'd1, 1'b1);
    endtask

    task automatic test_reset_mid();
        mode  = 2'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("mid busy before rst", int'(busy), 1);
        chk("mid err_count before rst", int'(err_count), 7);
        rst = 1'b1;
        #1;
        chk("mid rst dut_in", int'(dut_in), 0);
        chk("mid rst busy", int'(busy), 0);
        chk("mid rst max_err", int'(max_err), 0);
        chk("mid rst err_count", int'(err_count), 0);
        chk("mid rst done", int'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_sweep("after_rst", 2'd2, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_sweep("b2b first", 2'd2, 1'b0);
        run_sweep("b2b second", 2'd0, 1'b0);
    endtask

    task automatic test_start_held();
        int cyc   = 0;
        int ndone = 0;
        int first = 0;
        mode = 2'd1;
        sb_q.push_back(model(2'd1, 3));
        sb6_q.push_back(model(2'd2, 6));
        sb_q.push_back(model(2'd1, 3));
        sb6_q.push_back(model(2'd2, 6));
        start = 1'b1;
        @(negedge clk);
        while (ndone < 2 && cyc < 100) begin
            if (done) begin
                ndone++;
                check_results("held");
                if (ndone == 1) begin
                    first = cyc;
                    @(negedge clk);
                    cyc++;
                    chk("held done one cycle", int'(done), 0);
                    chk("held relaunch busy", int'(busy), 1);
                end else begin
                    chk("held sweep spacing", cyc - first, 19);
                end
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        chk("held done count", ndone, 2);
        while (sb_q.size() > 0) void'(sb_q.pop_front());
        while (sb6_q.size() > 0) void'(sb6_q.pop_front());
        @(negedge clk);
        chk("held done after release", int'(done), 1);
    endtask

    initial begin
        test_reset();
        test_exact();
        test_const3();
        test_stuck0();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        test_start_held();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
